// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions for the fetch stage.
// Contents: PC width and type, default reset PC, fetch FSM state encoding,
// and a helper that halfword-aligns redirect targets.
package fetch_ctrl_pkg;

    localparam int unsigned PcWidth = 16;
    typedef logic [PcWidth-1:0] pc_t;

    localparam pc_t DefaultResetPc = 16'h0000;

    // Fetch FSM encoding, kept as plain constants for legacy tools.
    localparam int unsigned StateWidth = 2;
    localparam logic [StateWidth-1:0] StRun   = 2'd0;
    localparam logic [StateWidth-1:0] StWait  = 2'd1;
    localparam logic [StateWidth-1:0] StFlush = 2'd2;
    localparam logic [StateWidth-1:0] StHalt  = 2'd3;

    // Instructions are halfword aligned, so bit 0 of a target is dropped.
    function automatic pc_t align_target(input pc_t target);
        return target & ~pc_t'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch control bundle between the fetch controller and its environment.
// master: fetch controller (consumes redirect/stall/halt/ready, drives PC and status).
// slave : environment (pipeline + instruction memory).
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic pc_src;       // redirect request
    pc_t  target;       // redirect address
    logic stall;        // downstream hazard stall
    logic halt;         // halt request from decode
    logic imem_rdy;     // instruction memory completes request this cycle
    pc_t  pc;           // current fetch address
    pc_t  pc_plus2;     // pc + 2, wraps
    logic imem_req;     // fetch request
    logic instr_valid;  // instruction at pc is valid this cycle
    logic flush;        // kill younger in-flight instructions
    logic halted;       // controller is in HALT
    logic err;          // sticky fetch-timeout fault

    modport master (
        input  pc_src, target, stall, halt, imem_rdy,
        output pc, pc_plus2, imem_req, instr_valid, flush, halted, err
    );

    modport slave (
        output pc_src, target, stall, halt, imem_rdy,
        input  pc, pc_plus2, imem_req, instr_valid, flush, halted, err
    );

endinterface

// File: rtl/fetch_ctrl_pc_reg.sv
// PC register (pc_reg): PcWidth-bit register with load enable and
// synchronous active-low reset to RESET_PC.
// Ports: clk, rst_n, load (enable), d (next PC), q (current PC).
module fetch_ctrl_pc_reg
    import fetch_ctrl_pkg::*;
#(
    parameter pc_t RESET_PC = DefaultResetPc
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  pc_t  d,
    output pc_t  q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences the PC, issues fetch requests,
// handles redirects (2-cycle penalty), stalls, halt and fetch timeout.
// Ports: clk, rst_n (synchronous, active-low), bus (fetch_ctrl_if.master).
// Parameters: RESET_PC (PC after reset), TIMEOUT (WAIT cycles before fault).
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter pc_t         RESET_PC = DefaultResetPc,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);

    // Counter only needs to reach TIMEOUT-1; the next WAIT cycle faults.
    localparam int unsigned CntWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

    logic [StateWidth-1:0] state_q, state_d;
    logic [CntWidth-1:0]   wait_cnt_q, wait_cnt_d;
    logic                  err_q, err_d;
    logic                  pc_load;
    pc_t                   pc_next, pc_q, pc_plus2;
    logic                  req, valid, flush;

    assign pc_plus2 = pc_q + pc_t'(2);

    fetch_ctrl_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (pc_next),
        .q     (pc_q)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;  // cleared unless we stay in WAIT
        err_d      = err_q;
        pc_load    = 1'b0;
        pc_next    = pc_plus2;
        req        = 1'b0;
        valid      = 1'b0;
        flush      = 1'b0;

        case (state_q)
            StRun, StWait: begin
                req = 1'b1;
                if (bus.pc_src) begin
                    flush   = 1'b1;
                    pc_load = 1'b1;
                    pc_next = align_target(bus.target);
                    state_d = StFlush;
                end else if (bus.halt) begin
                    state_d = StHalt;
                end else if (bus.imem_rdy) begin
                    state_d = StRun;
                    if (!bus.stall) begin
                        valid   = 1'b1;
                        pc_load = 1'b1;
                    end
                end else if (state_q == StWait && wait_cnt_q == CntLast) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else begin
                    state_d = StWait;
                    if (state_q == StWait) begin
                        wait_cnt_d = wait_cnt_q + CntWidth'(1);
                    end
                end
            end
            StFlush: begin
                // A second redirect during the bubble restarts the penalty.
                if (bus.pc_src) begin
                    flush   = 1'b1;
                    pc_load = 1'b1;
                    pc_next = align_target(bus.target);
                    state_d = StFlush;
                end else begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StHalt;  // terminal until reset
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // While rst_n is low the outputs look like the reset (RUN) state.
    assign bus.pc          = pc_q;
    assign bus.pc_plus2    = pc_plus2;
    assign bus.imem_req    = req | ~rst_n;
    assign bus.instr_valid = valid & rst_n;
    assign bus.flush       = flush & rst_n;
    assign bus.halted      = (state_q == StHalt) & rst_n;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: each cycle drives inputs, pushes the
// expected outputs to a scoreboard, and compares at the falling edge.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic        iv;
        logic        fl;
        logic        req;
        logic        hlt;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic rst, input logic src,
                         input logic [15:0] tgt, input logic stl, input logic hlt,
                         input logic rdy, input logic [15:0] e_pc, input logic e_iv,
                         input logic e_fl, input logic e_req, input logic e_hlt,
                         input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        bus.pc_src   = src;
        bus.target   = tgt;
        bus.stall    = stl;
        bus.halt     = hlt;
        bus.imem_rdy = rdy;
        sb_q.push_back('{tag, e_pc, e_iv, e_fl, e_req, e_hlt, e_err});
        @(negedge clk);
        e = sb_q.pop_front();
        check_eq({e.tag, ".pc"}, bus.pc, e.pc);
        check_eq({e.tag, ".pc_plus2"}, bus.pc_plus2, e.pc + 16'd2);
        check_eq({e.tag, ".instr_valid"}, 16'(bus.instr_valid), 16'(e.iv));
        check_eq({e.tag, ".flush"}, 16'(bus.flush), 16'(e.fl));
        check_eq({e.tag, ".imem_req"}, 16'(bus.imem_req), 16'(e.req));
        check_eq({e.tag, ".halted"}, 16'(bus.halted), 16'(e.hlt));
        check_eq({e.tag, ".err"}, 16'(bus.err), 16'(e.err));
        check_eq({e.tag, ".excl"}, 16'(bus.flush & bus.instr_valid), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.pc_src   = 1'b0;
        bus.target   = 16'h0;
        bus.stall    = 1'b0;
        bus.halt     = 1'b0;
        bus.imem_rdy = 1'b0;

        //     tag        rst src tgt       stl hlt rdy  pc       iv fl req hlt err
        // Reset dominates all inputs.
        cycle("rst0",     0,  1,  16'h0000, 0,  1,  1,   16'h0000, 0, 0, 1,  0,  0);
        // Sequential fetch.
        cycle("seq0",     1,  0,  16'h0000, 0,  0,  1,   16'h0000, 1, 0, 1,  0,  0);
        cycle("seq1",     1,  0,  16'h0000, 0,  0,  1,   16'h0002, 1, 0, 1,  0,  0);
        cycle("seq2",     1,  0,  16'h0000, 0,  0,  1,   16'h0004, 1, 0, 1,  0,  0);
        cycle("seq3",     1,  0,  16'h0000, 0,  0,  1,   16'h0006, 1, 0, 1,  0,  0);
        // Memory not ready for 3 cycles.
        cycle("wait0",    1,  0,  16'h0000, 0,  0,  0,   16'h0008, 0, 0, 1,  0,  0);
        cycle("wait1",    1,  0,  16'h0000, 0,  0,  0,   16'h0008, 0, 0, 1,  0,  0);
        cycle("wait2",    1,  0,  16'h0000, 0,  0,  0,   16'h0008, 0, 0, 1,  0,  0);
        cycle("wait_ok",  1,  0,  16'h0000, 0,  0,  1,   16'h0008, 1, 0, 1,  0,  0);
        // Stall holds PC.
        cycle("stall0",   1,  0,  16'h0000, 1,  0,  1,   16'h000A, 0, 0, 1,  0,  0);
        cycle("stall_ok", 1,  0,  16'h0000, 0,  0,  1,   16'h000A, 1, 0, 1,  0,  0);
        // Redirect to odd target, then redirect from 0x0010 to 0x0041.
        cycle("redir0",   1,  1,  16'h0011, 0,  0,  1,   16'h000C, 0, 1, 1,  0,  0);
        cycle("flush0",   1,  0,  16'h0000, 0,  0,  1,   16'h0010, 0, 0, 0,  0,  0);
        cycle("redir1",   1,  1,  16'h0041, 0,  0,  1,   16'h0010, 0, 1, 1,  0,  0);
        cycle("flush1",   1,  0,  16'h0000, 0,  0,  1,   16'h0040, 0, 0, 0,  0,  0);
        cycle("post1",    1,  0,  16'h0000, 0,  0,  1,   16'h0040, 1, 0, 1,  0,  0);
        // Wrap at top of address space.
        cycle("redir2",   1,  1,  16'hFFFF, 0,  0,  1,   16'h0042, 0, 1, 1,  0,  0);
        cycle("flush2",   1,  0,  16'h0000, 0,  0,  1,   16'hFFFE, 0, 0, 0,  0,  0);
        cycle("wrap",     1,  0,  16'h0000, 0,  0,  1,   16'hFFFE, 1, 0, 1,  0,  0);
        cycle("wrap1",    1,  0,  16'h0000, 0,  0,  1,   16'h0000, 1, 0, 1,  0,  0);
        cycle("wrap2",    1,  0,  16'h0000, 0,  0,  1,   16'h0002, 1, 0, 1,  0,  0);
        cycle("stall4",   1,  0,  16'h0000, 1,  0,  1,   16'h0004, 0, 0, 1,  0,  0);
        // Redirect beats halt; halt only acts once back in RUN.
        cycle("rd_halt",  1,  1,  16'h0100, 0,  1,  1,   16'h0004, 0, 1, 1,  0,  0);
        cycle("fl_halt",  1,  0,  16'h0000, 0,  1,  1,   16'h0100, 0, 0, 0,  0,  0);
        cycle("run100",   1,  0,  16'h0000, 0,  0,  1,   16'h0100, 1, 0, 1,  0,  0);
        cycle("halt_req", 1,  0,  16'h0000, 0,  1,  1,   16'h0102, 0, 0, 1,  0,  0);
        // HALT ignores everything.
        cycle("halted0",  1,  1,  16'h0200, 0,  0,  1,   16'h0102, 0, 0, 0,  1,  0);
        cycle("halted1",  1,  0,  16'h0000, 1,  1,  0,   16'h0102, 0, 0, 0,  1,  0);
        // Reset out of HALT.
        cycle("rst_h",    0,  0,  16'h0000, 0,  0,  1,   16'h0102, 0, 0, 1,  0,  0);
        // Timeout after 4 WAIT cycles.
        cycle("to_run",   1,  0,  16'h0000, 0,  0,  0,   16'h0000, 0, 0, 1,  0,  0);
        cycle("to_w1",    1,  0,  16'h0000, 0,  0,  0,   16'h0000, 0, 0, 1,  0,  0);
        cycle("to_w2",    1,  0,  16'h0000, 0,  0,  0,   16'h0000, 0, 0, 1,  0,  0);
        cycle("to_w3",    1,  0,  16'h0000, 0,  0,  0,   16'h0000, 0, 0, 1,  0,  0);
        cycle("to_w4",    1,  0,  16'h0000, 0,  0,  0,   16'h0000, 0, 0, 1,  0,  0);
        cycle("to_halt",  1,  0,  16'h0000, 0,  0,  1,   16'h0000, 0, 0, 0,  1,  1);
        // Reset clears the sticky fault on the following edge.
        cycle("rst_err",  0,  0,  16'h0000, 0,  0,  0,   16'h0000, 0, 0, 1,  0,  1);
        cycle("after",    1,  0,  16'h0000, 0,  0,  1,   16'h0000, 1, 0, 1,  0,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, the maximum cycles to wait for IMemRdy before faulting.
REQ-003 The block SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have PCSrc  input  1  redirect request from branch/jump resolution.
REQ-006 The block SHALL have Target  input  16  redirect address; bit 0 forced to 0 on load.
REQ-007 The block SHALL have Stall  input  1  downstream hazard stall.
REQ-008 The block SHALL have Halt  input  1  halt request from decode.
REQ-009 The block SHALL have IMemRdy  input  1  instruction memory ready; completes the current request in the same cycle.
REQ-010 The block SHALL have PC  output  16  current fetch address.
REQ-011 The block SHALL have PCPlus2  output  16  PC+2, combinational, modulo 2^16.
REQ-012 The block SHALL have IMemReq  output  1  fetch request to instruction memory.
REQ-013 The block SHALL have InstrValid  output  1  the instruction word at PC is valid this cycle.
REQ-014 The block SHALL have Flush  output  1  kill younger in-flight instructions this cycle.
REQ-015 The block SHALL have Halted  output  1  the block is in HALT.
REQ-016 The block SHALL have Err  output  1  sticky fetch-timeout fault.

Function
REQ-017 The block SHALL implement states RUN, WAIT, FLUSH and HALT.
REQ-018 IMemReq SHALL be 1 in RUN and WAIT, and 0 in FLUSH and HALT.
REQ-019 In RUN or WAIT, if IMemRdy=1 and Stall=0, InstrValid SHALL be 1, PC SHALL become PCPlus2 next cycle, and the next state SHALL be RUN.
REQ-020 In RUN or WAIT, if IMemRdy=1 and Stall=1, InstrValid SHALL be 0, PC SHALL hold, and the next state SHALL be RUN.
REQ-021 In RUN or WAIT, if IMemRdy=0, InstrValid SHALL be 0, PC SHALL hold, and the next state SHALL be WAIT.
REQ-022 The wait counter SHALL clear on entry to RUN and increment each WAIT cycle; on reaching TIMEOUT the next state SHALL be HALT and Err SHALL set.
REQ-023 PCSrc=1 in RUN, WAIT or FLUSH SHALL have top priority over all other conditions in this list.
REQ-024 On PCSrc=1 (REQ-023), Flush SHALL be 1 and InstrValid 0 that cycle, PC SHALL load {Target[15:1],1'b0} next cycle, the pending request SHALL be abandoned, and the next state SHALL be FLUSH.
REQ-025 FLUSH SHALL last exactly one cycle and then go to RUN, giving a 2-cycle redirect penalty; PC SHALL hold unless PCSrc=1 again.
REQ-026 Halt=1 with PCSrc=0 in RUN or WAIT SHALL make InstrValid 0 and the next state HALT, with PC holding.
REQ-027 HALT SHALL be terminal until reset; PCSrc, Stall, Halt and IMemRdy SHALL be ignored there; Halted=1 and Flush=0.
REQ-028 PC increment SHALL wrap: 16'hFFFE+2 gives 16'h0000, with no fault.
REQ-029 Simultaneous PCSrc and Halt SHALL take the redirect; Halt is re-evaluated once RUN is re-entered.
REQ-030 Flush and InstrValid SHALL never both be 1 in the same cycle.

Reset
REQ-031 While rst_n=0 at a rising clk edge, the block SHALL load state RUN, PC=RESET_PC, wait counter=0 and Err=0.
REQ-032 Reset SHALL override any state, including HALT or an outstanding WAIT; the first request SHALL issue in the first cycle after rst_n returns to 1.
REQ-033 During reset, Flush, InstrValid and Halted SHALL be 0 (decoded from the reset state) and IMemReq SHALL be 1.

Structure
REQ-034 The state encoding, the PC width (16) and the default RESET_PC SHALL live in the shared CPU package.
REQ-035 The PC storage SHALL be sub-module pc_reg: a 16-bit register with load enable and synchronous active-low reset to RESET_PC.
REQ-036 All outputs except PCPlus2 SHALL be decoded from registered state plus the current-cycle inputs; there SHALL be no combinational path from Target to any control output.

Verification
REQ-037 Scenario: reset, then IMemRdy=1 for 4 cycles -> PC reads 0,2,4,6 and InstrValid=1 each cycle.
REQ-038 Scenario: PC=0x0010 and PCSrc=1 with Target=0x0041 -> Flush=1 that cycle, then a FLUSH cycle with IMemReq=0, then PC=0x0040 with IMemReq=1.
REQ-039 Scenario: IMemRdy=0 for 3 cycles at PC=0x0008 -> WAIT with PC=0x0008 held, then IMemRdy=1 -> InstrValid=1 and the next PC=0x000A.
REQ-040 Scenario: TIMEOUT=4 with IMemRdy stuck at 0 -> HALT entered after 4 WAIT cycles, Err=1 and Halted=1; then rst_n=0 for 1 cycle -> PC=RESET_PC and Err=0.
REQ-041 Scenario: PC=0xFFFE with IMemRdy=1 -> next PC=0x0000; Stall=1 at PC=0x0004 -> PC holds and InstrValid=0.
REQ-042 Scenario: PCSrc=1 and Halt=1 together with Target=0x0100 -> redirect taken, PC=0x0100, HALT entered only when Halt is reasserted in RUN.
